// File: rtl/dmem_pkg.sv
// Shared types, sizing and the byte-merge helper for the data-memory arbiter.
package dmem_pkg;

  localparam int DEPTH_WORDS = 131072;
  localparam int IDX_W       = 17;

  // state  | meaning
  // IDLE   | waiting for a request; ready is offered to the granted requester
  // ACCESS | latched index on the memory port; full stores write here
  // MERGE  | read word returned; partial store writes the merged word
  // RESP   | one-cycle response pulse to the latched requester
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Byte i comes from wdata when be[i] is set, otherwise from the read word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                              input logic [31:0] rdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle; one instance per requester.
interface dmem_req_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit "last served" pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was served last, so requester 0 wins the next tie
  logic last_q;

  // Grant: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt_o != 2'b00) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (r0) and DMA (r1) accesses onto one synchronous data memory,
// turning partial stores into a read-merge-write sequence.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = dmem_pkg::DEPTH_WORDS,
  parameter int IDX_W       = dmem_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  dmem_req_if.slave        r0,
  dmem_req_if.slave        r1,
  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);
  import dmem_pkg::*;

  // First byte address past the memory; for a power-of-two depth this is the
  // same as "any address bit above the word index is set".
  localparam logic [33:0] BYTE_SPAN = {32'(DEPTH_WORDS), 2'b00};

  state_e           state_q;
  logic [IDX_W-1:0] mem_addr_q;
  logic             mem_we_q;
  logic             we_q;
  logic             err_q;
  logic             id_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;

  logic [1:0]       gnt;
  logic             accept;
  logic             sel_d;
  logic             we_d;
  logic [31:0]      addr_d;
  logic [31:0]      wdata_d;
  logic [3:0]       be_d;
  logic [IDX_W-1:0] idx_d;
  logic             err_d;
  logic             partial;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req_i ({r1.valid, r0.valid}),
    .en_i  ((state_q == IDLE) && !rst),
    .gnt_o (gnt)
  );

  assign r0.ready = gnt[0];
  assign r1.ready = gnt[1];
  assign accept   = |gnt;

  // Steer the granted requester's fields toward the latch.
  always_comb begin
    sel_d   = gnt[1];
    we_d    = sel_d ? r1.we    : r0.we;
    addr_d  = sel_d ? r1.addr  : r0.addr;
    wdata_d = sel_d ? r1.wdata : r0.wdata;
    be_d    = sel_d ? r1.be    : r0.be;
  end

  assign idx_d   = addr_d[IDX_W+1:2];
  assign err_d   = ({2'b00, addr_d} >= BYTE_SPAN);
  assign partial = we_q && !err_q && (be_q != 4'hF) && (be_q != 4'h0);

  // Transaction sequencer; memory strobes and response pulses are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      id_q        <= 1'b0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (accept) begin
            we_q       <= we_d;
            err_q      <= err_d;
            id_q       <= sel_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            mem_addr_q <= idx_d;
            mem_we_q   <= we_d && (be_d == 4'hF) && !err_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (partial) begin
            mem_we_q <= 1'b1;
            state_q  <= MERGE;
          end else begin
            mem_we_q          <= 1'b0;
            rsp_valid_q[id_q] <= 1'b1;
            rsp_err_q[id_q]   <= err_q;
            state_q           <= RESP;
          end
        end
        MERGE: begin
          mem_we_q          <= 1'b0;
          rsp_valid_q[id_q] <= 1'b1;
          rsp_err_q[id_q]   <= err_q;
          state_q           <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 2'b00;
          state_q     <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_wd   = (state_q == MERGE) ? merge_bytes(wdata_q, mem_rd, be_q) : wdata_q;

  // Read data is live memory output, exposed only on a load response without error.
  assign r0.rsp_valid = rsp_valid_q[0];
  assign r1.rsp_valid = rsp_valid_q[1];
  assign r0.rsp_err   = rsp_err_q[0];
  assign r1.rsp_err   = rsp_err_q[1];
  assign r0.rsp_rdata = (rsp_valid_q[0] && !we_q && !err_q) ? mem_rd : 32'h0;
  assign r1.rsp_rdata = (rsp_valid_q[1] && !we_q && !err_q) ? mem_rd : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: synchronous RAM model, directed cases and random traffic
// checked against a transaction-level reference memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int DW = 131072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  dmem_req_if r0();
  dmem_req_if r1();

  dmem_arbiter #(.DEPTH_WORDS(DW), .IDX_W(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0       (r0),
    .r1       (r1),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the DUT, with a preload port for the bench.
  logic [31:0] ram [0:DW-1];
  logic        pre_en  = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = 32'h0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_idx] <= pre_val;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wd;
      wr_count      <= wr_count + 1;
    end
    mem_rd <= ram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: memory contents as seen at transaction level.
  logic [31:0] ref_mem [0:DW-1];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (n == 0) begin
      r0.valid = v; r0.we = we; r0.addr = a; r0.wdata = wd; r0.be = be;
    end else begin
      r1.valid = v; r1.we = we; r1.addr = a; r1.wdata = wd; r1.be = be;
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? r0.ready : r1.ready;
  endfunction
  function automatic logic rsp_v(input int n);
    return (n == 0) ? r0.rsp_valid : r1.rsp_valid;
  endfunction
  function automatic logic [31:0] rsp_d(input int n);
    return (n == 0) ? r0.rsp_rdata : r1.rsp_rdata;
  endfunction
  function automatic logic rsp_e(input int n);
    return (n == 0) ? r0.rsp_err : r1.rsp_err;
  endfunction

  // Expected outcome of one transaction; applies stores to the reference memory.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int lat, output logic [31:0] rd,
                       output logic err, output int nwr);
    int idx;
    idx = int'(a[18:2]);
    err = (a >= 32'(DW * 4));
    rd  = 32'h0;
    nwr = 0;
    lat = 2;
    if (!err) begin
      if (!we) begin
        rd = ref_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        nwr = (be != 4'h0) ? 1 : 0;
        lat = (be == 4'hF || be == 4'h0) ? 2 : 3;
      end
    end
  endtask

  task automatic xact(input int n, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input string tag);
    int lat_e, nwr_e, w0, k, idx;
    logic [31:0] rd_e;
    logic err_e;
    bit got;
    idx = int'(a[18:2]);
    model(we, a, wd, be, lat_e, rd_e, err_e, nwr_e);
    @(negedge clk);
    drive(n, 1'b1, we, a, wd, be);
    #1;
    k = 0;
    while (!rdy(n) && k < 8) begin
      @(negedge clk); #1; k++;
    end
    chk({tag, " grant"}, 32'(rdy(n)), 32'd1);
    w0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    drive(n, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    got = 0;
    for (int c = 1; c <= 5 && !got; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      chk({tag, " other rsp"}, 32'(rsp_v(1 - n)), 32'd0);
      if (rsp_v(n)) begin
        got = 1;
        chk({tag, " latency"}, 32'(c), 32'(lat_e));
        chk({tag, " rdata"}, rsp_d(n), rd_e);
        chk({tag, " err"}, 32'(rsp_e(n)), 32'(err_e));
        chk({tag, " writes"}, 32'(wr_count - w0), 32'(nwr_e));
        if (!err_e) chk({tag, " ram word"}, ram[idx], ref_mem[idx]);
      end
    end
    chk({tag, " rsp seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int n, w0, k, n_g, n_r, exp_g, inflight, last;
    bit busy;
    logic we;
    logic [31:0] a, wd, v;
    logic [3:0] be;

    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);

    // Preload the used region (words 0..127 and the last word) while in reset.
    pre_en = 1'b1;
    for (int i = 0; i <= 128; i++) begin
      @(negedge clk);
      v = $urandom;
      pre_idx = (i == 128) ? DW - 1 : i;
      pre_val = v;
      ref_mem[pre_idx] = v;
    end
    @(negedge clk);
    pre_en = 1'b0;
    #1;
    chk("rst r0 ready", 32'(r0.ready), 32'd0);
    chk("rst r1 ready", 32'(r1.ready), 32'd0);
    chk("rst r0 rsp", 32'({r0.rsp_valid, r0.rsp_err}), 32'd0);
    chk("rst r1 rsp", 32'({r1.rsp_valid, r1.rsp_err}), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full store then load back.
    xact(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, "st full");
    chk("st full value", ram[64], 32'hDEADBEEF);
    xact(0, 1'b0, 32'h100, 32'h0, 4'h0, "ld full");

    // Partial store merge on word 0x40.
    xact(1, 1'b1, 32'h100, 32'h11223344, 4'hF, "st seed");
    xact(1, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, "st partial");
    chk("st partial value", ram[64], 32'h11BB33DD);
    xact(0, 1'b0, 32'h102, 32'h0, 4'h0, "ld partial");

    // Out-of-range load and store, in-range last word.
    xact(1, 1'b0, 32'h0008_0000, 32'h0, 4'h0, "ld oor");
    xact(0, 1'b1, 32'h0008_0100, 32'h12345678, 4'hF, "st oor");
    xact(0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'b0110, "st oor partial");
    xact(1, 1'b1, 32'h0007_FFFC, 32'hCAFEBABE, 4'hF, "st last");
    xact(1, 1'b0, 32'h0007_FFFC, 32'h0, 4'h0, "ld last");

    // Store with no byte enables.
    xact(0, 1'b1, 32'h100, 32'h55555555, 4'h0, "st be0");

    // Reset while a partial store from r0 is in MERGE.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h14, 32'hCAFEF00D, 4'b0011);
    #1;
    chk("mrst grant", 32'(r0.ready), 32'd1);
    w0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1;
    chk("mrst merge we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst we dropped", 32'(mem_we), 32'd0);
    chk("mrst addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst no write", 32'(wr_count - w0), 32'd0);
    chk("mrst ram", ram[5], ref_mem[5]);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("mrst no rsp", 32'({r0.rsp_valid, r1.rsp_valid}), 32'd0);
    end

    // Both requesters hold loads; grants alternate starting with r0.
    last = 1; busy = 0; inflight = 0; n_g = 0; n_r = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
    for (int c = 0; c < 40 && n_r < 4; c++) begin
      #1;
      if (rsp_v(0) || rsp_v(1)) begin
        chk("rr rsp owner", 32'(rsp_v(inflight)), 32'd1);
        chk("rr rsp other", 32'(rsp_v(1 - inflight)), 32'd0);
        chk("rr rdata", rsp_d(inflight), ref_mem[inflight == 1 ? 20 : 10]);
        busy = 0;
        n_r++;
      end
      if (rdy(0) || rdy(1)) begin
        chk("rr no overlap", 32'(busy), 32'd0);
        exp_g = (last == 1) ? 0 : 1;
        chk("rr grant", 32'(rdy(exp_g)), 32'd1);
        chk("rr single", 32'(rdy(1 - exp_g)), 32'd0);
        last = exp_g; inflight = exp_g; busy = 1; n_g++;
        if (n_g == 4) begin
          @(posedge clk);
          #1;
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
          drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
      end
      @(negedge clk);
    end
    chk("rr responses", 32'(n_r), 32'd4);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      n  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 9));
      if (k == 0)      a = $urandom | 32'h0008_0000;
      else if (k == 1) a = 32'h0007_FFFC | 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 127) << 2) | 32'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      xact(n, we, a, wd, be, "rand");
    end

    for (int i = 0; i < 128; i++) chk("final ram", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
